// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Holds the PC and the IF/ID pipeline register. The hazard unit controls
// stalls and bubbles. The next PC comes from the exception vector, the
// interrupt vector, a hold, or the ID-stage redirect mux. PC[31] is the
// kernel-mode bit.
//
// Ports
//   clk, reset           clock (rising edge) / async active-high reset
//   PCWrite              1 = PC may advance, 0 = stall PC
//   IF_ID_RegWrite       1 = IF/ID may load, 0 = hold
//   IF_ID_Clear          1 = load a bubble into IF/ID
//   PCSrc[1:0]           0 PC+4, 1 BranchTarget, 2 JumpTarget, 3 JrTarget
//   BranchTarget/JumpTarget/JrTarget  redirect targets from ID
//   IRQ                  level interrupt request (ignored in kernel mode)
//   ExcReq               one-cycle exception request from ID
//   imem_addr/imem_rdata instruction memory address (= PC) / async read data
//   IF_ID_Instr/IF_ID_PCPlus4/IF_ID_Valid  IF/ID register contents
//   IrqTaken             registered pulse when PC was redirected to IRQ_VEC
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IF_ID_RegWrite,
    input  logic        IF_ID_Clear,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] JrTarget,
    input  logic        IRQ,
    input  logic        ExcReq,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        IrqTaken
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;
    logic        irq_taken_q, irq_taken_d;

    logic [31:0] pc_plus4;
    logic        take_exc;
    logic        take_irq;
    logic        unused_jump_msb;

    // Sequential fetch wraps inside the current mode's half of the address
    // space, so the kernel bit never changes on PC+4.
    assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};

    // Interrupts cannot nest: only a user-mode PC can be redirected.
    assign take_exc = ExcReq;
    assign take_irq = IRQ && !pc_q[31] && !ExcReq;

    // The jump target's top bit is replaced by the current mode bit.
    assign unused_jump_msb = JumpTarget[31];

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcplus4_d   = pcplus4_q;
        valid_d     = valid_q;
        irq_taken_d = 1'b0;

        if (take_exc) begin
            pc_d = EXC_VEC;
        end else if (take_irq) begin
            pc_d        = IRQ_VEC;
            irq_taken_d = 1'b1;
        end else if (PCWrite) begin
            case (PCSrc)
                2'd1:    pc_d = BranchTarget;
                2'd2:    pc_d = {pc_q[31], JumpTarget[30:0]};
                // jr may leave kernel mode but can never enter it.
                2'd3:    pc_d = {JrTarget[31] & pc_q[31], JrTarget[30:0]};
                default: pc_d = pc_plus4;
            endcase
        end

        // A squashed fetch still records its PC+4 so the handler can
        // recover the return address.
        if (take_exc || take_irq || IF_ID_Clear) begin
            instr_d   = NOP_INSTR;
            pcplus4_d = pc_plus4;
            valid_d   = 1'b0;
        end else if (IF_ID_RegWrite) begin
            instr_d   = imem_rdata;
            pcplus4_d = pc_plus4;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            pcplus4_q   <= 32'h0000_0000;
            valid_q     <= 1'b0;
            irq_taken_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pcplus4_q   <= pcplus4_d;
            valid_q     <= valid_d;
            irq_taken_q <= irq_taken_d;
        end
    end

    assign imem_addr     = pc_q;
    assign IF_ID_Instr   = instr_q;
    assign IF_ID_PCPlus4 = pcplus4_q;
    assign IF_ID_Valid   = valid_q;
    assign IrqTaken      = irq_taken_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage. Directed scenarios use
// hand-derived constants. A randomized run compares against a behavioural
// model of the fetch rules.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, IF_ID_RegWrite, IF_ID_Clear;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget, JumpTarget, JrTarget;
    logic        IRQ, ExcReq;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_ID_Instr, IF_ID_PCPlus4;
    logic        IF_ID_Valid, IrqTaken;
    logic [31:0] imem_xor = 32'h0;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    // The instruction memory returns its own address, optionally scrambled.
    assign imem_rdata = imem_addr ^ imem_xor;

    if_stage dut (
        .clk(clk), .reset(reset),
        .PCWrite(PCWrite), .IF_ID_RegWrite(IF_ID_RegWrite), .IF_ID_Clear(IF_ID_Clear),
        .PCSrc(PCSrc), .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .JrTarget(JrTarget),
        .IRQ(IRQ), .ExcReq(ExcReq),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCPlus4(IF_ID_PCPlus4),
        .IF_ID_Valid(IF_ID_Valid), .IrqTaken(IrqTaken)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        PCWrite = 1'b1; IF_ID_RegWrite = 1'b1; IF_ID_Clear = 1'b0;
        PCSrc = 2'd0; BranchTarget = '0; JumpTarget = '0; JrTarget = '0;
        IRQ = 1'b0; ExcReq = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        tick();
        checks_total++;
        if ({imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, IrqTaken} !==
            {32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0})
            $display("[TB] FAIL reset: pc=%h instr=%h pc4=%h v=%b irq=%b, want 80000000 0 0 0 0",
                     imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, IrqTaken);
        else checks_passed++;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks_total++;
            if ({imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid} !==
                {32'h8000_0000 + 32'(4 * i), 32'h8000_0000 + 32'(4 * (i - 1)), 32'h8000_0000 + 32'(4 * i), 1'b1})
                $display("[TB] FAIL seq%0d: pc=%h instr=%h pc4=%h v=%b", i,
                         imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid);
            else checks_passed++;
        end
    endtask

    task automatic test_stall();
        PCWrite = 1'b0; IF_ID_RegWrite = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks_total++;
            if ({imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid} !==
                {32'h8000_0010, 32'h8000_000C, 32'h8000_0010, 1'b1})
                $display("[TB] FAIL stall%0d: pc=%h instr=%h pc4=%h v=%b, want 80000010 8000000c 80000010 1",
                         i, imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid);
            else checks_passed++;
        end
        set_idle();
        tick();
        checks_total++;
        if ({imem_addr, IF_ID_Instr, IF_ID_Valid} !== {32'h8000_0014, 32'h8000_0010, 1'b1})
            $display("[TB] FAIL stall_resume: pc=%h instr=%h v=%b, want 80000014 80000010 1",
                     imem_addr, IF_ID_Instr, IF_ID_Valid);
        else checks_passed++;
    endtask

    task automatic test_jump_flush();
        repeat (3) tick();
        PCSrc = 2'd2; JumpTarget = 32'h0000_0100; IF_ID_Clear = 1'b1;
        checks_total++;
        if (imem_addr !== 32'h8000_0020)
            $display("[TB] FAIL jump_setup: pc=%h want 80000020", imem_addr);
        else checks_passed++;
        tick();
        set_idle();
        checks_total++;
        if ({imem_addr, IF_ID_Instr, IF_ID_Valid} !== {32'h8000_0100, 32'h0, 1'b0})
            $display("[TB] FAIL jump_flush: pc=%h instr=%h v=%b, want 80000100 0 0",
                     imem_addr, IF_ID_Instr, IF_ID_Valid);
        else checks_passed++;
    endtask

    task automatic test_jr_user();
        PCSrc = 2'd3; JrTarget = 32'h0000_0040;
        tick();
        checks_total++;
        if ({imem_addr, IF_ID_Instr, IF_ID_PCPlus4} !== {32'h0000_0040, 32'h8000_0100, 32'h8000_0104})
            $display("[TB] FAIL jr_leave_kernel: pc=%h instr=%h pc4=%h, want 00000040 80000100 80000104",
                     imem_addr, IF_ID_Instr, IF_ID_PCPlus4);
        else checks_passed++;
        JrTarget = 32'h8000_0000;
        tick();
        set_idle();
        checks_total++;
        if ({imem_addr, IF_ID_Instr, IF_ID_PCPlus4} !== {32'h0000_0000, 32'h0000_0040, 32'h0000_0044})
            $display("[TB] FAIL jr_kernel_blocked: pc=%h instr=%h pc4=%h, want 00000000 00000040 00000044",
                     imem_addr, IF_ID_Instr, IF_ID_PCPlus4);
        else checks_passed++;
    endtask

    task automatic test_irq();
        PCSrc = 2'd1; BranchTarget = 32'h0000_0050;
        tick();
        set_idle();
        IRQ = 1'b1; PCWrite = 1'b0;
        tick();
        checks_total++;
        if ({imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, IrqTaken} !==
            {32'h8000_0004, 32'h0, 32'h0000_0054, 1'b0, 1'b1})
            $display("[TB] FAIL irq_take: pc=%h instr=%h pc4=%h v=%b irq=%b, want 80000004 0 00000054 0 1",
                     imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, IrqTaken);
        else checks_passed++;
        PCWrite = 1'b1;
        tick();
        checks_total++;
        if ({imem_addr, IF_ID_Instr, IF_ID_Valid, IrqTaken} !== {32'h8000_0008, 32'h8000_0004, 1'b1, 1'b0})
            $display("[TB] FAIL irq_no_nest: pc=%h instr=%h v=%b irq=%b, want 80000008 80000004 1 0",
                     imem_addr, IF_ID_Instr, IF_ID_Valid, IrqTaken);
        else checks_passed++;
        set_idle();
    endtask

    task automatic test_exc_irq();
        PCSrc = 2'd3; JrTarget = 32'h0000_0060;
        tick();
        set_idle();
        IRQ = 1'b1; ExcReq = 1'b1;
        tick();
        set_idle();
        checks_total++;
        if ({imem_addr, IF_ID_PCPlus4, IF_ID_Valid, IrqTaken} !== {32'h8000_0008, 32'h0000_0064, 1'b0, 1'b0})
            $display("[TB] FAIL exc_over_irq: pc=%h pc4=%h v=%b irq=%b, want 80000008 00000064 0 0",
                     imem_addr, IF_ID_PCPlus4, IF_ID_Valid, IrqTaken);
        else checks_passed++;
    endtask

    task automatic test_wrap();
        PCSrc = 2'd3; JrTarget = 32'h7FFF_FFFC;
        tick();
        set_idle();
        tick();
        checks_total++;
        if ({imem_addr, IF_ID_Instr, IF_ID_PCPlus4} !== {32'h0000_0000, 32'h7FFF_FFFC, 32'h0000_0000})
            $display("[TB] FAIL wrap_user: pc=%h instr=%h pc4=%h, want 00000000 7ffffffc 00000000",
                     imem_addr, IF_ID_Instr, IF_ID_PCPlus4);
        else checks_passed++;
        PCSrc = 2'd1; BranchTarget = 32'hFFFF_FFFC;
        tick();
        set_idle();
        tick();
        checks_total++;
        if ({imem_addr, IF_ID_Instr, IF_ID_PCPlus4} !== {32'h8000_0000, 32'hFFFF_FFFC, 32'h8000_0000})
            $display("[TB] FAIL wrap_kernel: pc=%h instr=%h pc4=%h, want 80000000 fffffffc 80000000",
                     imem_addr, IF_ID_Instr, IF_ID_PCPlus4);
        else checks_passed++;
    endtask

    task automatic test_reset_mid_stall();
        tick();
        PCWrite = 1'b0; IF_ID_RegWrite = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks_total++;
        if ({imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, IrqTaken} !==
            {32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0})
            $display("[TB] FAIL async_reset: pc=%h instr=%h pc4=%h v=%b irq=%b, want 80000000 0 0 0 0",
                     imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, IrqTaken);
        else checks_passed++;
        tick();
        reset = 1'b0;
        set_idle();
        tick();
        checks_total++;
        if ({imem_addr, IF_ID_Instr, IF_ID_Valid} !== {32'h8000_0004, 32'h8000_0000, 1'b1})
            $display("[TB] FAIL post_reset_fetch: pc=%h instr=%h v=%b, want 80000004 80000000 1",
                     imem_addr, IF_ID_Instr, IF_ID_Valid);
        else checks_passed++;
    endtask

    // Behavioural model: the mode bit is handled by masking, the IF/ID
    // register by the rule order "squash, clear, load, hold".
    task automatic test_random();
        logic [31:0] m_pc, m_instr, m_pc4, m_seq, m_next;
        logic        m_valid, m_irq, squash;
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        imem_xor = $urandom;
        m_pc = 32'h8000_0000; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_irq = 1'b0;
        for (int n = 0; n < 300; n++) begin
            PCWrite        = ($urandom_range(0, 3) != 0);
            IF_ID_RegWrite = ($urandom_range(0, 3) != 0);
            IF_ID_Clear    = ($urandom_range(0, 7) == 0);
            PCSrc          = 2'($urandom_range(0, 3));
            BranchTarget   = $urandom;
            JumpTarget     = $urandom;
            JrTarget       = $urandom;
            IRQ            = ($urandom_range(0, 5) == 0);
            ExcReq         = ($urandom_range(0, 15) == 0);

            m_seq  = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
            squash = 1'b0;
            m_irq  = 1'b0;
            if (ExcReq) begin
                m_next = 32'h8000_0008; squash = 1'b1;
            end else if (IRQ && m_pc < 32'h8000_0000) begin
                m_next = 32'h8000_0004; squash = 1'b1; m_irq = 1'b1;
            end else if (!PCWrite) begin
                m_next = m_pc;
            end else if (PCSrc == 2'd1) begin
                m_next = BranchTarget;
            end else if (PCSrc == 2'd2) begin
                m_next = (JumpTarget & 32'h7FFF_FFFF) | (m_pc & 32'h8000_0000);
            end else if (PCSrc == 2'd3) begin
                m_next = (m_pc >= 32'h8000_0000) ? JrTarget : (JrTarget & 32'h7FFF_FFFF);
            end else begin
                m_next = m_seq;
            end
            if (squash || IF_ID_Clear) begin
                m_instr = 32'h0; m_pc4 = m_seq; m_valid = 1'b0;
            end else if (IF_ID_RegWrite) begin
                m_instr = m_pc ^ imem_xor; m_pc4 = m_seq; m_valid = 1'b1;
            end
            m_pc = m_next;

            tick();
            checks_total++;
            if ({imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, IrqTaken} !==
                {m_pc, m_instr, m_pc4, m_valid, m_irq})
                $display("[TB] FAIL random%0d: pc=%h instr=%h pc4=%h v=%b irq=%b, want %h %h %h %b %b",
                         n, imem_addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, IrqTaken,
                         m_pc, m_instr, m_pc4, m_valid, m_irq);
            else checks_passed++;
        end
        imem_xor = 32'h0;
        set_idle();
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        #3;
        test_reset();
        test_sequential();
        test_stall();
        test_jump_flush();
        test_jr_user();
        test_irq();
        test_exc_irq();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
